// File: rtl/fetch_unit.sv
// fetch_unit: REQ/WAIT/ISSUE instruction fetcher with branch/JAL decode for the PC mux.
// Optional FETCH_ALIGN_CHECK_EN adds align_fault and a HALT state for misaligned PCs.
module fetch_unit #(
  parameter int address_width = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [address_width-1:0] PC,
  input  logic                     EQ,
  output logic                     imem_req,
  output logic [address_width-1:0] imem_addr,
  input  logic                     imem_gnt,
  input  logic                     imem_rvalid,
  input  logic [31:0]              imem_rdata,
  output logic [31:0]              instr,
  output logic                     instr_valid,
  input  logic                     instr_ready,
  output logic                     pc_en,
  output logic                     PCsrc,
  output logic [address_width-1:0] ImmOp
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic                     align_fault
`endif
);
`ifdef FETCH_ALIGN_CHECK_EN
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_ISSUE, S_HALT} state_t;
`else
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_ISSUE} state_t;
`endif
  state_t r_state, w_next;
  logic [31:0] r_instr;
  logic w_misalign, w_issue, w_br, w_jal;
  logic [address_width-1:0] w_imm_b, w_imm_j;
`ifdef FETCH_ALIGN_CHECK_EN
  assign w_misalign = |PC[1:0];
`else
  assign w_misalign = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_REQ;
      r_instr <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_WAIT && imem_rvalid) r_instr <= imem_rdata;
    end
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_REQ:   w_next = w_misalign ? state_t'(2'd3) : imem_gnt ? S_WAIT : S_REQ;
      S_WAIT:  w_next = imem_rvalid ? S_ISSUE : S_WAIT;
      S_ISSUE: w_next = instr_ready ? S_REQ : S_ISSUE;
      default: w_next = r_state;
    endcase
  end
  assign w_br    = r_instr[6:0] == 7'b1100011;
  assign w_jal   = r_instr[6:0] == 7'b1101111;
  assign w_imm_b = {{(address_width-12){r_instr[31]}}, r_instr[7], r_instr[30:25], r_instr[11:8], 1'b0};
  assign w_imm_j = {{(address_width-20){r_instr[31]}}, r_instr[19:12], r_instr[20], r_instr[30:21], 1'b0};
  always_comb begin
    w_issue     = rst && r_state == S_ISSUE;
    imem_req    = rst && r_state == S_REQ && !w_misalign;
    imem_addr   = PC;
    instr       = r_instr;
    instr_valid = w_issue;
    pc_en       = w_issue && instr_ready;
    PCsrc       = w_issue && (w_jal || (w_br && r_instr[14:12] == 3'b000 && EQ) ||
                              (w_br && r_instr[14:12] == 3'b001 && !EQ));
    ImmOp       = !w_issue ? '0 : w_br ? w_imm_b : w_jal ? w_imm_j : '0;
  end
`ifdef FETCH_ALIGN_CHECK_EN
  assign align_fault = r_state == S_HALT;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: table-driven fetch/decode vectors plus backpressure, stale-rvalid and reset sequences.
module tb_fetch_unit;
  logic clk = 0, rst = 0, EQ = 0, imem_gnt = 0, imem_rvalid = 0, instr_ready = 0;
  logic [31:0] PC, imem_addr, imem_rdata = 0, instr, ImmOp;
  logic imem_req, instr_valid, pc_en, PCsrc;
  logic ld = 0;
  logic [31:0] ld_val = 0;
  int checks = 0, failures = 0, pulses = 0, p0;
`ifdef FETCH_ALIGN_CHECK_EN
  logic align_fault;
`endif
  typedef struct {
    logic [31:0] start, rdata;
    logic        eq, pcsrc;
    logic [31:0] imm, next;
  } vec_t;
  vec_t v[8];

  fetch_unit #(.address_width(32)) dut (
    .clk(clk), .rst(rst), .PC(PC), .EQ(EQ), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .instr(instr),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .pc_en(pc_en), .PCsrc(PCsrc),
    .ImmOp(ImmOp)
`ifdef FETCH_ALIGN_CHECK_EN
    , .align_fault(align_fault)
`endif
  );

  always #5 clk = ~clk;

  // Environment PC register: PC+4 or PC+ImmOp on pc_en, with a bench load port
  always @(posedge clk) begin
    if (!rst) PC <= 0;
    else if (ld) PC <= ld_val;
    else if (pc_en) PC <= PCsrc ? PC + ImmOp : PC + 4;
    if (rst && pc_en) pulses <= pulses + 1;
  end

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", n, a, e);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load_pc(input logic [31:0] val);
    ld = 1;
    ld_val = val;
    tick();
    ld = 0;
  endtask

  initial begin
    v[0] = '{32'h000, 32'h00000013, 1'b0, 1'b0, 32'h00000000, 32'h00000004};
    v[1] = '{32'h100, 32'hFE000EE3, 1'b1, 1'b1, 32'hFFFFFFFC, 32'h000000FC};
    v[2] = '{32'h100, 32'hFE000EE3, 1'b0, 1'b0, 32'hFFFFFFFC, 32'h00000104};
    v[3] = '{32'h200, 32'h0080006F, 1'b0, 1'b1, 32'h00000008, 32'h00000208};
    v[4] = '{32'h100, 32'hFE001EE3, 1'b0, 1'b1, 32'hFFFFFFFC, 32'h000000FC};
    v[5] = '{32'h100, 32'hFE001EE3, 1'b1, 1'b0, 32'hFFFFFFFC, 32'h00000104};
    v[6] = '{32'h004, 32'hFF9FF06F, 1'b0, 1'b1, 32'hFFFFFFF8, 32'hFFFFFFFC};
    v[7] = '{32'h300, 32'h00002163, 1'b1, 1'b0, 32'h00000002, 32'h00000304};

    tick();
    tick();
    chk("rst_req", {31'd0, imem_req}, 0);
    chk("rst_valid", {31'd0, instr_valid}, 0);
    chk("rst_pc_en", {31'd0, pc_en}, 0);
    chk("rst_pcsrc", {31'd0, PCsrc}, 0);
    chk("rst_imm", ImmOp, 0);
    chk("rst_instr", instr, 0);
    rst = 1;
    tick();
    chk("post_rst_req", {31'd0, imem_req}, 1);
    chk("post_rst_addr", imem_addr, 0);

    for (int i = 0; i < 8; i++) begin
      load_pc(v[i].start);
      chk($sformatf("v%0d_req", i), {31'd0, imem_req}, 1);
      chk($sformatf("v%0d_addr", i), imem_addr, v[i].start);
      imem_gnt = 1;
      tick();
      imem_gnt = 0;
      imem_rvalid = 1;
      imem_rdata = v[i].rdata;
      EQ = v[i].eq;
      #1;
      chk($sformatf("v%0d_wait_req", i), {31'd0, imem_req}, 0);
      chk($sformatf("v%0d_wait_pcsrc", i), {31'd0, PCsrc}, 0);
      tick();
      imem_rvalid = 0;
      imem_rdata = 32'hDEADBEEF;
      instr_ready = 1;
      #1;
      chk($sformatf("v%0d_valid", i), {31'd0, instr_valid}, 1);
      chk($sformatf("v%0d_instr", i), instr, v[i].rdata);
      chk($sformatf("v%0d_pcsrc", i), {31'd0, PCsrc}, {31'd0, v[i].pcsrc});
      chk($sformatf("v%0d_imm", i), ImmOp, v[i].imm);
      chk($sformatf("v%0d_pc_en", i), {31'd0, pc_en}, 1);
      tick();
      instr_ready = 0;
      chk($sformatf("v%0d_next_req", i), {31'd0, imem_req}, 1);
      chk($sformatf("v%0d_next_addr", i), imem_addr, v[i].next);
      chk($sformatf("v%0d_after_pc_en", i), {31'd0, pc_en}, 0);
      chk($sformatf("v%0d_after_imm", i), ImmOp, 0);
    end

    // Slow grant, rvalid coincident with gnt, then held-off consumer
    load_pc(32'h40);
    for (int i = 0; i < 3; i++) begin
      chk("bp_req_hold", {31'd0, imem_req}, 1);
      chk("bp_addr_hold", imem_addr, 32'h40);
      tick();
    end
    imem_gnt = 1;
    imem_rvalid = 1;
    imem_rdata = 32'h00000013;
    tick();
    imem_gnt = 0;
    imem_rvalid = 0;
    chk("bp_gnt_rvalid_ignored", {31'd0, instr_valid}, 0);
    tick();
    chk("bp_still_wait", {31'd0, instr_valid}, 0);
    imem_rvalid = 1;
    imem_rdata = 32'h0080006F;
    tick();
    imem_rvalid = 0;
    imem_rdata = 32'hDEADBEEF;
    p0 = pulses;
    for (int i = 0; i < 4; i++) begin
      chk("bp_valid", {31'd0, instr_valid}, 1);
      chk("bp_instr", instr, 32'h0080006F);
      chk("bp_imm", ImmOp, 32'h8);
      chk("bp_pc_en_low", {31'd0, pc_en}, 0);
      tick();
    end
    instr_ready = 1;
    #1;
    chk("bp_pc_en", {31'd0, pc_en}, 1);
    tick();
    instr_ready = 0;
    chk("bp_pulses", pulses - p0, 1);
    chk("bp_next_addr", imem_addr, 32'h48);

    // Reset while waiting for data; the late rvalid must not land
    load_pc(32'h80);
    imem_gnt = 1;
    tick();
    imem_gnt = 0;
    rst = 0;
    tick();
    chk("mr_instr_clr", instr, 0);
    chk("mr_req", {31'd0, imem_req}, 0);
    chk("mr_valid", {31'd0, instr_valid}, 0);
    rst = 1;
    imem_rvalid = 1;
    imem_rdata = 32'h0080006F;
    #1;
    chk("mr_fresh_req", {31'd0, imem_req}, 1);
    chk("mr_fresh_addr", imem_addr, 0);
    tick();
    imem_rvalid = 0;
    chk("mr_stale_valid", {31'd0, instr_valid}, 0);
    chk("mr_stale_instr", instr, 0);
    chk("mr_req_hold", {31'd0, imem_req}, 1);
    imem_gnt = 1;
    tick();
    imem_gnt = 0;
    chk("mr_wait_instr", instr, 0);
    imem_rvalid = 1;
    imem_rdata = 32'h00000013;
    tick();
    imem_rvalid = 0;
    chk("mr_new_instr", instr, 32'h00000013);
    instr_ready = 1;
    tick();
    instr_ready = 0;
    chk("mr_next_addr", imem_addr, 32'h4);

`ifdef FETCH_ALIGN_CHECK_EN
    load_pc(32'h2);
    chk("al_req0", {31'd0, imem_req}, 0);
    chk("al_fault0", {31'd0, align_fault}, 0);
    imem_gnt = 1;
    instr_ready = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("al_fault", {31'd0, align_fault}, 1);
      chk("al_req", {31'd0, imem_req}, 0);
      chk("al_pc_en", {31'd0, pc_en}, 0);
    end
    imem_gnt = 0;
    instr_ready = 0;
    rst = 0;
    tick();
    chk("al_fault_rst", {31'd0, align_fault}, 0);
    rst = 1;
`else
    load_pc(32'h2);
    chk("na_req", {31'd0, imem_req}, 1);
    chk("na_addr", imem_addr, 32'h2);
    imem_gnt = 1;
    tick();
    imem_gnt = 0;
    imem_rvalid = 1;
    imem_rdata = 32'h00000013;
    tick();
    imem_rvalid = 0;
    instr_ready = 1;
    tick();
    instr_ready = 0;
    chk("na_next_addr", imem_addr, 32'h6);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
